// File: rtl/vga_sync_monitor_if.sv
// Bundle of observed VGA pins and monitor results.
//   master : the video source / consumer side (drives sync + colour, reads results)
//   slave  : the monitor (reads sync + colour, drives lock, errors, counts, pixels)
interface vga_sync_monitor_if;
    logic        h_sync;
    logic        v_sync;
    logic [3:0]  vga_red;
    logic [3:0]  vga_green;
    logic [3:0]  vga_blue;
    logic        locked;
    logic        frame_start;
    logic        h_err;
    logic        v_err;
    logic [7:0]  err_count;
    logic [11:0] line_len;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [11:0] pix_rgb;

    modport master (
        output h_sync, v_sync, vga_red, vga_green, vga_blue,
        input  locked, frame_start, h_err, v_err, err_count, line_len,
        input  pix_valid, pix_x, pix_y, pix_rgb
    );

    modport slave (
        input  h_sync, v_sync, vga_red, vga_green, vga_blue,
        output locked, frame_start, h_err, v_err, err_count, line_len,
        output pix_valid, pix_x, pix_y, pix_rgb
    );
endinterface

// File: rtl/vga_sync_monitor.sv
// VGA timing monitor: checks hsync/vsync period and pulse width against the
// configured mode, locks after LOCK_FRAMES clean frames and, while locked,
// captures active-region pixels with their coordinates.
//   clk : pixel clock
//   rst : asynchronous active-high reset
//   bus : slave side of vga_sync_monitor_if (sync/colour in, status/pixels out)
module vga_sync_monitor #(
    parameter int H_ACTIVE        = 640,
    parameter int H_BACK          = 48,
    parameter int H_SYNC          = 96,
    parameter int H_TOTAL         = 800,
    parameter int V_ACTIVE        = 480,
    parameter int V_BACK          = 33,
    parameter int V_SYNC          = 2,
    parameter int V_TOTAL         = 525,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2
) (
    input logic               clk,
    input logic               rst,
    vga_sync_monitor_if.slave bus
);
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_SW   = 12'(H_SYNC);
    localparam logic [11:0] H_LO   = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_HI   = 12'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_SW   = 10'(V_SYNC);
    localparam logic [9:0]  V_LO   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_HI   = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_e;
    state_e state_q, state_d;

    // Input register stage; sync levels are normalised to 1 = active.
    logic        h_pin_act, v_pin_act;
    logic        h_act_q, h_act_p_q, v_act_q, v_act_p_q;
    logic [11:0] rgb_q;

    assign h_pin_act = (SYNC_ACTIVE_LOW != 0) ? ~bus.h_sync : bus.h_sync;
    assign v_pin_act = (SYNC_ACTIVE_LOW != 0) ? ~bus.v_sync : bus.v_sync;

    // Sync history resets to the active level so no leading edge can be
    // manufactured by reset release; a pulse already in progress is ignored
    // until a real leading edge has been seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_act_q   <= 1'b1;
            h_act_p_q <= 1'b1;
            v_act_q   <= 1'b1;
            v_act_p_q <= 1'b1;
            rgb_q     <= '0;
        end else begin
            h_act_q   <= h_pin_act;
            h_act_p_q <= h_act_q;
            v_act_q   <= v_pin_act;
            v_act_p_q <= v_act_q;
            rgb_q     <= {bus.vga_red, bus.vga_green, bus.vga_blue};
        end
    end

    logic h_lead, h_trail, v_lead, v_trail;
    assign h_lead  =  h_act_q & ~h_act_p_q;
    assign h_trail = ~h_act_q &  h_act_p_q;
    assign v_lead  =  v_act_q & ~v_act_p_q;
    assign v_trail = ~v_act_q &  v_act_p_q;

    logic [11:0] h_cnt_q, h_wid_q, line_len_q;
    logic [9:0]  v_cnt_q, v_wid_q;
    logic        h_seen_q, v_seen_q, h_first_q, v_first_q;
    logic [7:0]  good_q, good_d, err_cnt_q;
    logic        h_err_q, v_err_q, fs_q;
    logic        pix_valid_q;
    logic [9:0]  pix_x_q, pix_y_q;
    logic [11:0] pix_rgb_q;
    logic        h_err_d, v_err_d, any_err, enter_search;
    logic        locked, pix_en;

    // Period checks are skipped on the first edge after (re)entering SEARCH;
    // width checks need a leading edge seen since reset.
    always_comb begin
        h_err_d = 1'b0;
        v_err_d = 1'b0;
        if (h_lead && !h_first_q && h_cnt_q != H_LAST) h_err_d = 1'b1;
        if (h_trail && h_seen_q && h_wid_q != H_SW)    h_err_d = 1'b1;
        if (v_lead && !v_first_q && v_cnt_q != V_LAST) v_err_d = 1'b1;
        if (v_trail && v_seen_q && v_wid_q != V_SW)    v_err_d = 1'b1;
    end
    assign any_err = h_err_d | v_err_d;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEARCH;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            SEARCH: if (v_lead) begin
                state_d = TRACK;
                good_d  = '0;
            end
            TRACK: if (any_err) begin
                state_d = SEARCH;
                good_d  = '0;
            end else if (v_lead) begin
                good_d = good_q + 8'd1;
                if (good_d >= LOCK_N) state_d = LOCKED;
            end
            LOCKED: if (any_err) begin
                state_d = SEARCH;
                good_d  = '0;
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase
        enter_search = (state_d == SEARCH) && (state_q != SEARCH);
    end

    // FSM: outputs. h_cnt lags the sample in rgb_q by one, so rgb_q holds
    // the pixel that belongs to the current h_cnt/v_cnt position.
    always_comb begin
        locked = (state_q == LOCKED);
        pix_en = locked && (h_cnt_q >= H_LO) && (h_cnt_q < H_HI)
                        && (v_cnt_q >= V_LO) && (v_cnt_q < V_HI);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q     <= '0;
            h_wid_q     <= '0;
            line_len_q  <= '0;
            v_cnt_q     <= '0;
            v_wid_q     <= '0;
            h_seen_q    <= 1'b0;
            v_seen_q    <= 1'b0;
            h_first_q   <= 1'b1;
            v_first_q   <= 1'b1;
            err_cnt_q   <= '0;
            h_err_q     <= 1'b0;
            v_err_q     <= 1'b0;
            fs_q        <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_rgb_q   <= '0;
        end else begin
            h_cnt_q <= h_lead ? '0 : ((h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 12'd1);
            if (h_lead)                       h_wid_q <= 12'd1;
            else if (h_act_q && h_wid_q != '1) h_wid_q <= h_wid_q + 12'd1;
            if (h_lead) begin
                h_seen_q   <= 1'b1;
                line_len_q <= (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 12'd1;
            end

            // vsync clear beats the same-cycle hsync increment
            if (v_lead)                          v_cnt_q <= '0;
            else if (h_lead && v_cnt_q != '1)    v_cnt_q <= v_cnt_q + 10'd1;
            // width in lines, counting an hsync edge coincident with the vsync edge
            if (v_lead)                                     v_wid_q <= {9'd0, h_lead};
            else if (v_act_q && h_lead && v_wid_q != '1)    v_wid_q <= v_wid_q + 10'd1;
            if (v_lead) v_seen_q <= 1'b1;

            h_first_q <= enter_search | (h_first_q & ~h_lead);
            v_first_q <= enter_search | (v_first_q & ~v_lead);

            if (any_err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 8'd1;
            h_err_q <= h_err_d;
            v_err_q <= v_err_d;
            fs_q    <= v_lead;

            pix_valid_q <= pix_en;
            if (pix_en) begin
                pix_x_q   <= 10'(h_cnt_q - H_LO);
                pix_y_q   <= v_cnt_q - V_LO;
                pix_rgb_q <= rgb_q;
            end
        end
    end

    assign bus.locked      = locked;
    assign bus.frame_start = fs_q;
    assign bus.h_err       = h_err_q;
    assign bus.v_err       = v_err_q;
    assign bus.err_count   = err_cnt_q;
    assign bus.line_len    = line_len_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.pix_rgb     = pix_rgb_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor using a reduced video mode (20x12 total) so that
// whole frames stay short. Pixel captures are checked against a scoreboard
// of expected {x, y, rgb, arrival cycle}.
module tb_vga_sync_monitor;
    localparam int H_ACTIVE = 8, H_BACK = 3, H_SYNC = 4, H_TOTAL = 20;
    localparam int V_ACTIVE = 6, V_BACK = 2, V_SYNC = 2, V_TOTAL = 12;
    localparam int H_LO = H_SYNC + H_BACK, H_HI = H_LO + H_ACTIVE;
    localparam int V_LO = V_SYNC + V_BACK, V_HI = V_LO + V_ACTIVE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vga_sync_monitor_if vif ();

    vga_sync_monitor #(
        .H_ACTIVE(H_ACTIVE), .H_BACK(H_BACK), .H_SYNC(H_SYNC), .H_TOTAL(H_TOTAL),
        .V_ACTIVE(V_ACTIVE), .V_BACK(V_BACK), .V_SYNC(V_SYNC), .V_TOTAL(V_TOTAL),
        .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(vif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0, n_fail = 0;
    int          cyc = 0;
    bit          sb_on = 1'b0;
    int          strobes = 0;
    int          h_err_n = 0, v_err_n = 0, both_n = 0, fs_n = 0;
    logic [11:0] last_rgb = '0;

    always @(posedge clk) cyc++;

    // Pulse counters and scoreboard consumer
    always @(negedge clk) begin
        if (vif.h_err) h_err_n++;
        if (vif.v_err) v_err_n++;
        if (vif.h_err && vif.v_err) both_n++;
        if (vif.frame_start) fs_n++;
        if (sb_on && vif.pix_valid) begin
            exp_t e;
            strobes++;
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL pix_unexpected: got x=%0d y=%0d rgb=%h, expected no strobe", vif.pix_x, vif.pix_y, vif.pix_rgb);
            end else begin
                e = sb_q.pop_front();
                if (vif.pix_x !== e.x || vif.pix_y !== e.y || vif.pix_rgb !== e.rgb || cyc !== e.due) begin
                    n_fail++;
                    $display("FAIL pix_data: got x=%0d y=%0d rgb=%h cyc=%0d, expected x=%0d y=%0d rgb=%h cyc=%0d",
                             vif.pix_x, vif.pix_y, vif.pix_rgb, cyc, e.x, e.y, e.rgb, e.due);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive samples p0..len-1 of one line. The monitor sees sample p with
    // h_cnt = p-1 and v_cnt = line, so active pixels sit at p-1 in [H_LO,H_HI).
    task automatic drive_line(input int len, input int p0, input bit vs, input int line, input bit sb);
        for (int p = p0; p < len; p++) begin
            int          hc;
            logic [11:0] rgb;
            exp_t        e;
            @(negedge clk);
            vif.h_sync = (p < H_SYNC) ? 1'b0 : 1'b1;
            vif.v_sync = vs ? 1'b0 : 1'b1;
            hc = p - 1;
            rgb = '0;
            if (hc >= H_LO && hc < H_HI && line >= V_LO && line < V_HI) begin
                e.x = 10'(hc - H_LO);
                e.y = 10'(line - V_LO);
                rgb = (e.x == 0 && e.y == 0) ? 12'hF0A : 12'($urandom);
                e.rgb = rgb;
                e.due = cyc + 2;
                if (sb) begin
                    sb_q.push_back(e);
                    last_rgb = rgb;
                end
            end
            vif.vga_red   = rgb[11:8];
            vif.vga_green = rgb[7:4];
            vif.vga_blue  = rgb[3:0];
        end
    endtask

    task automatic drive_frame(input bit sb);
        for (int l = 0; l < V_TOTAL; l++) drive_line(H_TOTAL, 0, l < V_SYNC, l, sb);
    endtask

    // Release reset mid-active-line, finish that frame, then two clean frames.
    task automatic resync();
        @(negedge clk);
        rst = 1'b0;
        drive_line(H_TOTAL, 10, 1'b0, 7, 1'b0);
        for (int l = 8; l < V_TOTAL; l++) drive_line(H_TOTAL, 0, 1'b0, l, 1'b0);
        drive_frame(1'b0);
        drive_frame(1'b0);
    endtask

    task automatic test_reset();
        vif.h_sync = 1'b1; vif.v_sync = 1'b1;
        vif.vga_red = '0; vif.vga_green = '0; vif.vga_blue = '0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++; if (vif.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", vif.locked); end
        n_tests++; if (vif.err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", vif.err_count); end
        n_tests++; if (vif.line_len !== 12'd0) begin n_fail++; $display("FAIL reset_line_len: got %0d want 0", vif.line_len); end
        n_tests++; if ({vif.pix_valid, vif.pix_x, vif.pix_y, vif.pix_rgb} !== 33'd0) begin
            n_fail++; $display("FAIL reset_pix: got v=%b x=%0d y=%0d rgb=%h want 0", vif.pix_valid, vif.pix_x, vif.pix_y, vif.pix_rgb); end
        n_tests++; if ({vif.h_err, vif.v_err, vif.frame_start} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 000", {vif.h_err, vif.v_err, vif.frame_start}); end
    endtask

    task automatic test_lock();
        fs_n = 0; h_err_n = 0; v_err_n = 0;
        @(negedge clk);
        rst = 1'b0;
        drive_line(H_TOTAL, 10, 1'b0, 7, 1'b0);
        for (int l = 8; l < V_TOTAL; l++) drive_line(H_TOTAL, 0, 1'b0, l, 1'b0);
        drive_frame(1'b0);
        drive_frame(1'b0);
        n_tests++; if (vif.locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b want 0", vif.locked); end
        drive_line(H_TOTAL, 0, 1'b1, 0, 1'b0);
        n_tests++; if (vif.locked !== 1'b1) begin n_fail++; $display("FAIL lock_acquire: got %b want 1", vif.locked); end
        n_tests++; if (h_err_n !== 0 || v_err_n !== 0) begin n_fail++; $display("FAIL lock_no_err: got h=%0d v=%0d want 0 0", h_err_n, v_err_n); end
        n_tests++; if (vif.err_count !== 8'd0) begin n_fail++; $display("FAIL lock_err_count: got %0d want 0", vif.err_count); end
        n_tests++; if (vif.line_len !== 12'(H_TOTAL)) begin n_fail++; $display("FAIL lock_line_len: got %0d want %0d", vif.line_len, H_TOTAL); end
        n_tests++; if (fs_n !== 3) begin n_fail++; $display("FAIL frame_start_count: got %0d want 3", fs_n); end
    endtask

    task automatic test_pixels();
        for (int l = 1; l < V_TOTAL; l++) drive_line(H_TOTAL, 0, l < V_SYNC, l, 1'b0);
        strobes = 0;
        sb_on = 1'b1;
        drive_frame(1'b1);
        sb_on = 1'b0;
        n_tests++; if (strobes !== H_ACTIVE * V_ACTIVE) begin n_fail++; $display("FAIL pix_count: got %0d want %0d", strobes, H_ACTIVE * V_ACTIVE); end
        n_tests++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL pix_missing: got %0d left want 0", sb_q.size()); end
        n_tests++; if (vif.pix_valid !== 1'b0 || vif.pix_x !== 10'(H_ACTIVE - 1) || vif.pix_y !== 10'(V_ACTIVE - 1) || vif.pix_rgb !== last_rgb) begin
            n_fail++; $display("FAIL pix_hold: got v=%b x=%0d y=%0d rgb=%h want 0 %0d %0d %h",
                               vif.pix_valid, vif.pix_x, vif.pix_y, vif.pix_rgb, H_ACTIVE - 1, V_ACTIVE - 1, last_rgb); end
        sb_q.delete();
    endtask

    task automatic test_short_line();
        h_err_n = 0;
        for (int l = 0; l < V_TOTAL; l++) begin
            drive_line((l == 3) ? H_TOTAL - 1 : H_TOTAL, 0, l < V_SYNC, l, 1'b0);
            if (l == 4) begin
                n_tests++; if (h_err_n !== 1) begin n_fail++; $display("FAIL short_h_err: got %0d want 1", h_err_n); end
                n_tests++; if (vif.locked !== 1'b0) begin n_fail++; $display("FAIL short_unlock: got %b want 0", vif.locked); end
                n_tests++; if (vif.line_len !== 12'(H_TOTAL - 1)) begin n_fail++; $display("FAIL short_line_len: got %0d want %0d", vif.line_len, H_TOTAL - 1); end
            end
        end
        n_tests++; if (vif.err_count !== 8'd1) begin n_fail++; $display("FAIL short_err_count: got %0d want 1", vif.err_count); end
        drive_frame(1'b0);
        drive_frame(1'b0);
        n_tests++; if (vif.locked !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %b want 0", vif.locked); end
        drive_line(H_TOTAL, 0, 1'b1, 0, 1'b0);
        n_tests++; if (vif.locked !== 1'b1) begin n_fail++; $display("FAIL relock: got %b want 1", vif.locked); end
        for (int l = 1; l < V_TOTAL; l++) drive_line(H_TOTAL, 0, l < V_SYNC, l, 1'b0);
        n_tests++; if (h_err_n !== 1) begin n_fail++; $display("FAIL short_h_err_total: got %0d want 1", h_err_n); end
    endtask

    task automatic test_vsync_width();
        h_err_n = 0; v_err_n = 0;
        for (int l = 0; l < V_TOTAL; l++) begin
            drive_line(H_TOTAL, 0, l < 3, l, 1'b0);
            if (l == 2) begin
                n_tests++; if (v_err_n !== 0) begin n_fail++; $display("FAIL vwidth_early: got %0d want 0", v_err_n); end
                n_tests++; if (vif.locked !== 1'b1) begin n_fail++; $display("FAIL vwidth_still_locked: got %b want 1", vif.locked); end
            end
            if (l == 3) begin
                n_tests++; if (v_err_n !== 1) begin n_fail++; $display("FAIL vwidth_v_err: got %0d want 1", v_err_n); end
                n_tests++; if (vif.locked !== 1'b0) begin n_fail++; $display("FAIL vwidth_unlock: got %b want 0", vif.locked); end
            end
        end
        n_tests++; if (vif.err_count !== 8'd2 || h_err_n !== 0) begin
            n_fail++; $display("FAIL vwidth_counts: got err_count=%0d h_err=%0d want 2 0", vif.err_count, h_err_n); end
    endtask

    task automatic test_err_saturation();
        h_err_n = 0; v_err_n = 0;
        for (int l = 0; l < 300; l++) drive_line(H_TOTAL - 1, 0, 1'b0, 0, 1'b0);
        n_tests++; if (h_err_n !== 299 || v_err_n !== 0) begin n_fail++; $display("FAIL sat_pulses: got h=%0d v=%0d want 299 0", h_err_n, v_err_n); end
        n_tests++; if (vif.err_count !== 8'd255) begin n_fail++; $display("FAIL sat_err_count: got %0d want 255", vif.err_count); end
    endtask

    task automatic test_reset_mid_line();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        resync();
        for (int l = 0; l < 6; l++) drive_line(H_TOTAL, 0, l < V_SYNC, l, 1'b0);
        drive_line(H_LO + 4, 0, 1'b0, 6, 1'b0);
        n_tests++; if (vif.locked !== 1'b1 || vif.pix_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_active: got locked=%b pix_valid=%b want 1 1", vif.locked, vif.pix_valid); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (vif.locked !== 1'b0 || vif.pix_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_status: got locked=%b pix_valid=%b want 0 0", vif.locked, vif.pix_valid); end
        n_tests++; if ({vif.pix_x, vif.pix_y, vif.pix_rgb, vif.err_count, vif.line_len} !== 52'd0) begin
            n_fail++; $display("FAIL async_reset_values: got x=%0d y=%0d rgb=%h err=%0d len=%0d want 0",
                               vif.pix_x, vif.pix_y, vif.pix_rgb, vif.err_count, vif.line_len); end
    endtask

    // Last line of a frame one cycle short and frame one line short:
    // period errors on both axes land on the same cycle.
    task automatic test_simultaneous_err();
        h_err_n = 0; v_err_n = 0; both_n = 0;
        resync();
        for (int l = 0; l < V_TOTAL - 1; l++)
            drive_line((l == V_TOTAL - 2) ? H_TOTAL - 1 : H_TOTAL, 0, l < V_SYNC, l, 1'b0);
        drive_line(H_TOTAL, 0, 1'b1, 0, 1'b0);
        n_tests++; if (h_err_n !== 1 || v_err_n !== 1 || both_n !== 1) begin
            n_fail++; $display("FAIL simul_pulses: got h=%0d v=%0d both=%0d want 1 1 1", h_err_n, v_err_n, both_n); end
        n_tests++; if (vif.err_count !== 8'd1) begin n_fail++; $display("FAIL simul_err_count: got %0d want 1", vif.err_count); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_pixels();
        test_short_line();
        test_vsync_width();
        test_err_saturation();
        test_reset_mid_line();
        test_simultaneous_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_ACTIVE 640 visible pixels per line
  H_BACK 48 back-porch pixels
  H_SYNC 96 hsync pulse width, pixels
  H_TOTAL 800 pixels per line
  V_ACTIVE 480 visible lines
  V_BACK 33 back-porch lines
  V_SYNC 2 vsync pulse width, lines
  V_TOTAL 525 lines per frame
  SYNC_ACTIVE_LOW 1 sync polarity
  LOCK_FRAMES 2 consecutive clean frames required to lock
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk in 1 pixel clock (25 MHz)
  rst in 1 asynchronous, active-high reset
  h_sync in 1 observed horizontal sync
  v_sync in 1 observed vertical sync
  vga_red/vga_green/vga_blue in 4 each observed colour
  locked out 1 timing lock held
  frame_start out 1 one-cycle pulse on each vsync leading edge
  h_err out 1 one-cycle pulse on horizontal timing violation
  v_err out 1 one-cycle pulse on vertical timing violation
  err_count out 8 saturating count of errors
  line_len out 12 last measured line length, in cycles
  pix_valid out 1 captured pixel strobe
  pix_x out 10 column, 0..H_ACTIVE-1
  pix_y out 10 row, 0..V_ACTIVE-1
  pix_rgb out 12 {red, green, blue}

Function
REQ-003 All inputs SHALL be registered once. An "edge" means a registered-sync transition to or from the active level, where the active level is set by SYNC_ACTIVE_LOW.
REQ-004 h_cnt (12 bits) SHALL clear to 0 on an hsync leading edge; otherwise it SHALL increment, saturating at 4095.
REQ-005 On an hsync leading edge, line_len SHALL load h_cnt+1. If h_cnt != H_TOTAL-1, h_err SHALL pulse, except on the first edge after entering SEARCH.
REQ-006 The hsync width counter SHALL count active cycles. On the hsync trailing edge, h_err SHALL pulse if the width != H_SYNC.
REQ-007 v_cnt (10 bits) SHALL increment on each hsync leading edge. A vsync leading edge SHALL clear v_cnt to 0, and this clear SHALL win over a same-cycle increment.
REQ-008 On a vsync leading edge, if v_cnt != V_TOTAL-1, v_err SHALL pulse, except on the first edge after entering SEARCH. frame_start SHALL pulse on every vsync leading edge.
REQ-009 The vsync width SHALL be the count of hsync leading edges while vsync is active, including a coincident first edge. On the vsync trailing edge, v_err SHALL pulse if the width != V_SYNC.
REQ-010 FSM states SHALL be SEARCH, TRACK and LOCKED. Transitions:
  - SEARCH -> TRACK on a vsync leading edge.
  - TRACK: a good-frame counter SHALL increment on each error-free vsync leading edge; the state SHALL go to LOCKED when the count reaches LOCK_FRAMES.
  - TRACK or LOCKED -> SEARCH on any h_err or v_err; the good-frame counter SHALL clear.
REQ-011 locked SHALL be 1 exactly while the FSM is in LOCKED.
REQ-012 err_count SHALL increment on each cycle in which h_err or v_err is asserted, in any state, and SHALL saturate at 255.
REQ-013 The active region is H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE and V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_ACTIVE.
REQ-014 In LOCKED, inside the active region, pix_valid SHALL be 1 and pix_x, pix_y and pix_rgb SHALL be the offset coordinates and colour. All are registered; the latency from input pins to output SHALL be 2 cycles.
REQ-015 Outside LOCKED or outside the active region, pix_valid SHALL be 0 and pix_x, pix_y and pix_rgb SHALL hold their last values.
REQ-016 A simultaneous h_err and v_err SHALL increment err_count by 1 only.

Reset
REQ-017 While rst is high, asynchronously:
  - FSM SHALL be in SEARCH.
  - All counters SHALL be 0, including h_cnt, v_cnt and the good-frame counter.
  - All outputs SHALL be 0, including line_len, err_count and pix_*.
REQ-018 Reset asserted mid-frame SHALL discard all measurements. After release, the first vsync leading edge SHALL be treated as the first edge after entering SEARCH.

Verification
REQ-019 Ideal 640x480@60 stream, reset released mid-frame -> after the first vsync leading edge, locked=1 two frames later; h_err=v_err=0; err_count=0; line_len=800.
REQ-020 Locked stream, pixel (0,0)=12'hF0A -> two cycles later: pix_valid=1, pix_x=0, pix_y=0, pix_rgb=12'hF0A; 640x480 strobes per frame.
REQ-021 Locked stream, one line shortened to 799 cycles -> h_err pulses once, locked=0, err_count=1, line_len=799; relocks after 3 vsync edges (1 to TRACK, then 2 clean frames).
REQ-022 vsync held for 3 lines -> v_err pulses at the vsync trailing edge, FSM returns to SEARCH.
REQ-023 300 consecutive bad lines -> err_count=255 (saturated), no wrap.
REQ-024 rst pulsed mid-active-line -> all outputs 0 immediately, including locked=0 and pix_valid=0.
